// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the unified memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 14
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data stages;
// data wins by default, a bounded data streak lets a waiting fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MEM_AW       = 14,
    parameter int MAX_D_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_IF   = 2'd1;
    localparam logic [1:0] RESP_D    = 2'd2;
    logic [SW-1:0] streak_q, streak_d;
    logic [1:0]    resp_q, resp_d;
    logic          if_gnt, d_gnt, fetch_due, if_rvalid, d_rvalid;
    logic          unused_addr;
    assign fetch_due = bus.if_req && streak_q == STREAK_MAX;
    assign d_gnt     = !rst && bus.d_req && !fetch_due;
    assign if_gnt    = !rst && bus.if_req && !d_gnt;
    // Streak only counts data wins that actually made fetch wait.
    always_comb begin
        streak_d = (!bus.if_req || if_gnt) ? '0 :
                   (d_gnt && streak_q != STREAK_MAX) ? streak_q + 1'b1 : streak_q;
        resp_d   = if_gnt ? RESP_IF : (d_gnt && !bus.d_we) ? RESP_D : RESP_NONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
            resp_q   <= RESP_NONE;
        end else begin
            streak_q <= streak_d;
            resp_q   <= resp_d;
        end
    end
    // A response pending at a reset edge is suppressed while rst is high.
    assign if_rvalid     = !rst && resp_q == RESP_IF;
    assign d_rvalid      = !rst && resp_q == RESP_D;
    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : '0;
    assign bus.mem_en    = if_gnt | d_gnt;
    assign bus.mem_we    = d_gnt & bus.d_we;
    assign bus.mem_addr  = if_gnt ? bus.if_addr[MEM_AW+1:2] : d_gnt ? bus.d_addr[MEM_AW+1:2] : '0;
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
    assign unused_addr   = ^{bus.if_addr[ADDR_W-1:MEM_AW+2], bus.if_addr[1:0],
                             bus.d_addr[ADDR_W-1:MEM_AW+2], bus.d_addr[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed streak/reset sequences and random traffic vs a reference model
module tb_mem_port_arbiter;
    localparam int MAX = 4;
    logic clk = 0;
    logic rst = 1;
    logic ir = 0, dr = 0, dwe = 0;
    logic [31:0] ia = 0, da = 0, dwd = 0;
    logic [31:0] mem [0:16383];
    logic [31:0] mem_rdata_q = 0;
    int checks = 0, errors = 0;
    int m_streak = 0, m_pend = 0, cur_row = -1;
    logic [31:0] m_data = 0;
    bit m_ig, m_dg, last_ig, last_dg;
    logic [31:0] shadow [int];

    typedef struct {
        int rst, ir; logic [31:0] ia;
        int dr, dwe; logic [31:0] da, dwd;
        int eig, edg, ewe, eaddr, eirv, edrv; logic [31:0] erd;
    } vec_t;
    vec_t vt [12];

    mem_port_arbiter_if bus ();
    mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.if_req    = ir;
    assign bus.if_addr   = ia;
    assign bus.d_req     = dr;
    assign bus.d_we      = dwe;
    assign bus.d_addr    = da;
    assign bus.d_wdata   = dwd;
    assign bus.mem_rdata = mem_rdata_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (bus.mem_en) mem_rdata_q <= mem[bus.mem_addr];
    end

    function automatic logic [31:0] init_word(int i);
        return 32'h9E3779B9 * i ^ 32'h5A5A0000;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a / 4) % 16384);
    endfunction

    function automatic logic [31:0] exp_word(int a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    task automatic step();
        int ea;
        bit irv, drv;
        #2;
        m_ig = 0;
        m_dg = 0;
        if (!rst) begin
            if (ir && dr) begin
                m_dg = m_streak < MAX;
                m_ig = !m_dg;
            end else begin
                m_ig = ir;
                m_dg = dr;
            end
        end
        ea  = m_ig ? widx(ia) : m_dg ? widx(da) : 0;
        irv = !rst && m_pend == 1;
        drv = !rst && m_pend == 2;
        chk("if_gnt", bus.if_gnt, m_ig);
        chk("d_gnt", bus.d_gnt, m_dg);
        chk("gnt_excl", bus.if_gnt & bus.d_gnt, 0);
        chk("mem_en", bus.mem_en, m_ig | m_dg);
        chk("mem_we", bus.mem_we, m_dg & dwe);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_wdata, m_dg ? dwd : 0);
        chk("if_rvalid", bus.if_rvalid, irv);
        chk("d_rvalid", bus.d_rvalid, drv);
        chk("if_rdata", bus.if_rdata, irv ? m_data : 0);
        chk("d_rdata", bus.d_rdata, drv ? m_data : 0);
        if (cur_row >= 0) begin
            chk($sformatf("row%0d_if_gnt", cur_row), bus.if_gnt, vt[cur_row].eig);
            chk($sformatf("row%0d_d_gnt", cur_row), bus.d_gnt, vt[cur_row].edg);
            chk($sformatf("row%0d_mem_we", cur_row), bus.mem_we, vt[cur_row].ewe);
            chk($sformatf("row%0d_mem_addr", cur_row), bus.mem_addr, vt[cur_row].eaddr);
            chk($sformatf("row%0d_if_rvalid", cur_row), bus.if_rvalid, vt[cur_row].eirv);
            chk($sformatf("row%0d_d_rvalid", cur_row), bus.d_rvalid, vt[cur_row].edrv);
            chk($sformatf("row%0d_rdata", cur_row), bus.if_rdata | bus.d_rdata, vt[cur_row].erd);
        end
        last_ig = bus.if_gnt;
        last_dg = bus.d_gnt;
        @(posedge clk);
        if (rst) begin
            m_streak = 0;
            m_pend = 0;
        end else begin
            m_pend = m_ig ? 1 : (m_dg && !dwe) ? 2 : 0;
            if (m_ig) m_data = exp_word(widx(ia));
            else if (m_dg && !dwe) m_data = exp_word(widx(da));
            if (m_dg && dwe) shadow[widx(da)] = dwd;
            if (!ir || m_ig) m_streak = 0;
            else if (m_dg) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; ir = 0; dr = 0; dwe = 0;
        step();
    endtask

    task automatic run_pat(string pat, string nm);
        for (int i = 0; i < pat.len(); i++) begin
            ir = 1; dr = 1; dwe = 0;
            step();
            chk($sformatf("%s[%0d]", nm, i), {last_ig, last_dg}, (pat[i] == 8'h49) ? 2'b10 : 2'b01);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = init_word(i);
        vt[0]  = '{1, 1, 32'h10, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, init_word(4)};
        vt[3]  = '{0, 0, 0, 1, 1, 32'h20, 32'hCAFEBABE, 0, 1, 1, 8, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 0, 32'hFFFF0023, 0, 0, 1, 0, 8, 0, 0, 0};
        vt[6]  = '{0, 1, 32'h1004, 0, 0, 0, 0, 1, 0, 0, 'h401, 0, 1, 32'hCAFEBABE};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, init_word('h401)};
        vt[8]  = '{0, 1, 32'h40, 1, 1, 32'h40, 32'h12345678, 0, 1, 1, 'h10, 0, 0, 0};
        vt[9]  = '{1, 1, 32'h40, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{0, 0, 0, 1, 0, 32'h40, 0, 0, 1, 0, 'h10, 0, 0, 0};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678};
        @(negedge clk);
        for (int r = 0; r < 12; r++) begin
            rst = vt[r].rst != 0; ir = vt[r].ir != 0; ia = vt[r].ia;
            dr = vt[r].dr != 0; dwe = vt[r].dwe != 0; da = vt[r].da; dwd = vt[r].dwd;
            cur_row = r;
            step();
        end
        cur_row = -1;
        // Contended loads: four data wins then one fetch, repeating.
        ia = 32'h100; da = 32'h200;
        idle();
        run_pat("DDDDIDDDDI", "contend");
        // Alternating single requesters: one grant per cycle, responses routed back.
        idle();
        for (int i = 0; i < 8; i++) begin
            ir = i % 2 == 0; dr = i % 2 == 1; dwe = 0;
            ia = 32'(i * 8); da = 32'(i * 8 + 4);
            step();
            chk($sformatf("alt[%0d]", i), {last_ig, last_dg}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        // Reset right after a load grant drops its response and clears the streak.
        idle();
        run_pat("DDD", "pre_rst");
        rst = 1; ir = 1; dr = 1;
        step();
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        rst = 0;
        run_pat("DDDDI", "post_rst");
        // Fetch dropping its request for a cycle clears the streak.
        idle();
        run_pat("DDD", "pre_ifdrop");
        ir = 0; dr = 1;
        step();
        chk("ifdrop_gnt", {last_ig, last_dg}, 2'b01);
        run_pat("DDDDI", "post_ifdrop");
        // Data dropping its request hands the cycle to fetch, which clears the streak.
        idle();
        run_pat("DDD", "pre_ddrop");
        ir = 1; dr = 0;
        step();
        chk("ddrop_gnt", {last_ig, last_dg}, 2'b10);
        run_pat("DDDDI", "post_ddrop");
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 99) == 0;
            if (!(ir && !last_ig && $urandom_range(0, 7) != 0)) begin
                ir = $urandom_range(0, 2) != 0;
                ia = ($urandom() & 32'hFFF00000) | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
            end
            if (!(dr && !last_dg && $urandom_range(0, 7) != 0)) begin
                dr = $urandom_range(0, 2) != 0;
                dwe = $urandom_range(0, 2) == 0;
                da = ($urandom() & 32'hFFF00000) | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
                dwd = $urandom();
            end
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
